// File: rtl/pc_ctrl_if.sv
// Instruction-control bundle between decode/ALU and the next-PC stage.
// Master drives instruction and LUT-load fields; slave returns fetch address and status.
interface pc_ctrl_if #(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 16,
    parameter int CNT_W     = 16
) ();
    localparam int IDX_W = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

    logic             start;
    logic             stall_i;
    logic             halt_i;
    logic             branch_en;
    logic             branch_type;
    logic             equal_i;
    logic [IDX_W-1:0] target_idx;
    logic             lut_we;
    logic [IDX_W-1:0] lut_waddr;
    logic [PC_W-1:0]  lut_wdata;
    logic [PC_W-1:0]  pc_o;
    logic             valid_o;
    logic             taken_o;
    logic             done_o;
    logic [CNT_W-1:0] instr_cnt_o;

    modport master (
        output start, stall_i, halt_i, branch_en, branch_type, equal_i, target_idx,
        output lut_we, lut_waddr, lut_wdata,
        input  pc_o, valid_o, taken_o, done_o, instr_cnt_o
    );

    modport slave (
        input  start, stall_i, halt_i, branch_en, branch_type, equal_i, target_idx,
        input  lut_we, lut_waddr, lut_wdata,
        output pc_o, valid_o, taken_o, done_o, instr_cnt_o
    );
endinterface

// File: rtl/pc_ctrl.sv
// Next-PC stage: sequencing, BNE/BEQ resolution via target LUT, HALT, retire counter.
// All outputs registered, one cycle after the decision; stall_i holds the PC with no retire.
module pc_ctrl #(
    parameter int              PC_W      = 10,
    parameter int              LUT_DEPTH = 16,
    parameter logic [PC_W-1:0] START_PC  = '0,
    parameter int              CNT_W     = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_ctrl_if.slave  bus
);
    localparam int IDX_W = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic             r_valid;
    logic             r_taken;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic [PC_W-1:0]  r_lut [LUT_DEPTH];

    logic             w_br_taken;
    logic [PC_W-1:0]  w_target;
    logic [CNT_W-1:0] w_cnt_inc;

    // BNE (type 0) takes on inequality, BEQ (type 1) on equality.
    assign w_br_taken = bus.branch_en && (bus.branch_type ? bus.equal_i : !bus.equal_i);
    assign w_target   = r_lut[bus.target_idx];
    assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    // Write lands at the edge, so a same-cycle branch still sees the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_lut[i] <= '0;
            end
        end else if (bus.lut_we) begin
            r_lut[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_valid <= 1'b0;
            r_taken <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_taken <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= RUN;
                        r_pc    <= START_PC;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.stall_i) begin
                        r_cnt <= w_cnt_inc;
                        if (bus.halt_i) begin
                            r_state <= DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_br_taken) begin
                            r_state <= FLUSH;
                            r_pc    <= w_target;
                            r_valid <= 1'b0;
                            r_taken <= 1'b1;
                        end else begin
                            r_pc <= r_pc + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    r_state <= RUN;
                    r_valid <= 1'b1;
                end
                DONE: begin
                    if (bus.start) begin
                        r_state <= RUN;
                        r_pc    <= START_PC;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_o        = r_pc;
    assign bus.valid_o     = r_valid;
    assign bus.taken_o     = r_taken;
    assign bus.done_o      = r_done;
    assign bus.instr_cnt_o = r_cnt;
endmodule
